fpu_wb_arbiter: RTL and testbench

// - Collects FPU results from the fixed-latency FMA pipe, the fixed-latency simple-ops pipe and the

---
 rtl/fpu_wb_pkg.sv | 23 ++
 rtl/fpu_wb_resv_shreg.sv | 75 +++++++
 rtl/fpu_wb_arbiter.sv | 119 +++++++++++
 tb/tb_fpu_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_wb_pkg.sv
// rtl/fpu_wb_pkg.sv - shared types and default latencies for the FPU writeback arbiter
package fpu_wb_pkg;

    localparam int FLEN_DEF       = 64;
    localparam int RESV_RD_W      = 5;
    localparam int EXC_W_DEF      = 5;
    localparam int FMA_LAT_DEF    = 4;
    localparam int SIMPLE_LAT_DEF = 2;

    typedef struct packed {
        logic                 valid;
        logic                 is_fma;
        logic [RESV_RD_W-1:0] rd;
    } resv_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FMA,
        SRC_SIMPLE,
        SRC_DIV
    } wb_src_e;

endpackage

// File: rtl/fpu_wb_resv_shreg.sv
// rtl/fpu_wb_resv_shreg.sv - writeback slot reservation shift register with issue gating and kill
module fpu_wb_resv_shreg
    import fpu_wb_pkg::*;
#(
    parameter int FMA_LAT    = FMA_LAT_DEF,
    parameter int SIMPLE_LAT = SIMPLE_LAT_DEF,
    parameter int RD_W       = RESV_RD_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_is_fma,
    input  logic [RD_W-1:0] issue_rd,
    output logic            issue_ready,
    input  logic            issue_kill,
    output resv_entry_t     slot0,
    output logic            slot0_killed
);

    localparam int YW = $clog2(FMA_LAT);

    resv_entry_t        resv_q   [FMA_LAT];
    resv_entry_t        resv_eff [FMA_LAT];
    logic [FMA_LAT-1:0] killed_q;
    logic [FMA_LAT-1:0] killed_eff;
    logic               young_valid_q;
    logic [YW-1:0]      young_idx_q;
    logic [YW-1:0]      wr_idx;
    logic [YW-1:0]      chk_idx;
    logic               fire;

    // Kill acts on the current view so a simple op killed while already in slot 0 never writes back.
    always_comb begin
        for (int i = 0; i < FMA_LAT; i++) begin
            resv_eff[i]   = resv_q[i];
            killed_eff[i] = killed_q[i];
            if (issue_kill && young_valid_q && (young_idx_q == YW'(i))) begin
                resv_eff[i].valid = 1'b0;
                killed_eff[i]     = 1'b1;
            end
        end
    end

    assign wr_idx       = issue_is_fma ? YW'(FMA_LAT - 2) : YW'(SIMPLE_LAT - 2);
    assign chk_idx      = wr_idx + YW'(1);
    assign issue_ready  = !reset && !resv_q[chk_idx].valid;
    assign fire         = issue_valid && issue_ready;
    assign slot0        = resv_eff[0];
    assign slot0_killed = killed_eff[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FMA_LAT; i++) begin
                resv_q[i] <= '0;
            end
            killed_q      <= '0;
            young_valid_q <= 1'b0;
            young_idx_q   <= '0;
        end else begin
            for (int i = 0; i < FMA_LAT - 1; i++) begin
                resv_q[i]   <= resv_eff[i+1];
                killed_q[i] <= killed_eff[i+1];
            end
            resv_q[FMA_LAT-1]   <= '0;
            killed_q[FMA_LAT-1] <= 1'b0;
            if (fire) begin
                resv_q[wr_idx]   <= '{valid: 1'b1, is_fma: issue_is_fma, rd: RESV_RD_W'(issue_rd)};
                killed_q[wr_idx] <= 1'b0;
            end
            young_valid_q <= fire;
            young_idx_q   <= wr_idx;
        end
    end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// rtl/fpu_wb_arbiter.sv - merges FMA, simple and div/sqrt results onto one registered FP writeback port
module fpu_wb_arbiter
    import fpu_wb_pkg::*;
#(
    parameter int FLEN       = FLEN_DEF,
    parameter int RD_W       = RESV_RD_W,
    parameter int EXC_W      = EXC_W_DEF,
    parameter int FMA_LAT    = FMA_LAT_DEF,
    parameter int SIMPLE_LAT = SIMPLE_LAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_is_fma,
    input  logic [RD_W-1:0]  issue_rd,
    output logic             issue_ready,
    input  logic             issue_kill,
    input  logic             fma_res_valid,
    input  logic [FLEN-1:0]  fma_res_data,
    input  logic [EXC_W-1:0] fma_res_exc,
    input  logic             simple_res_valid,
    input  logic [FLEN-1:0]  simple_res_data,
    input  logic [EXC_W-1:0] simple_res_exc,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [RD_W-1:0]  div_rd,
    input  logic [FLEN-1:0]  div_data,
    input  logic [EXC_W-1:0] div_exc,
    output logic             wb_valid,
    output logic [RD_W-1:0]  wb_rd,
    output logic [FLEN-1:0]  wb_data,
    output logic [EXC_W-1:0] wb_exc,
    output logic             err_protocol
);

    resv_entry_t slot0;
    logic        slot0_killed;
    wb_src_e     src;
    logic        fma_match;
    logic        simple_match;
    logic        err_now;

    fpu_wb_resv_shreg #(
        .FMA_LAT   (FMA_LAT),
        .SIMPLE_LAT(SIMPLE_LAT),
        .RD_W      (RD_W)
    ) u_resv (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_is_fma(issue_is_fma),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .issue_kill  (issue_kill),
        .slot0       (slot0),
        .slot0_killed(slot0_killed)
    );

    assign div_ready = !reset && !slot0.valid;

    always_comb begin
        src = SRC_NONE;
        if (slot0.valid) begin
            src = slot0.is_fma ? SRC_FMA : SRC_SIMPLE;
        end else if (div_valid) begin
            src = SRC_DIV;
        end
    end

    // A killed slot still owns its pipe's result, so a late result there is dropped without error.
    assign fma_match    = slot0.is_fma && (slot0.valid || slot0_killed);
    assign simple_match = !slot0.is_fma && (slot0.valid || slot0_killed);

    assign err_now = (fma_res_valid && !fma_match)
                   || (simple_res_valid && !simple_match)
                   || (src == SRC_FMA && !fma_res_valid)
                   || (src == SRC_SIMPLE && !simple_res_valid)
                   || (fma_res_valid && simple_res_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exc       <= '0;
            err_protocol <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            err_protocol <= err_protocol || err_now;
            case (src)
                SRC_FMA: begin
                    if (fma_res_valid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= RD_W'(slot0.rd);
                        wb_data  <= fma_res_data;
                        wb_exc   <= fma_res_exc;
                    end
                end
                SRC_SIMPLE: begin
                    if (simple_res_valid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= RD_W'(slot0.rd);
                        wb_data  <= simple_res_data;
                        wb_exc   <= simple_res_exc;
                    end
                end
                SRC_DIV: begin
                    wb_valid <= 1'b1;
                    wb_rd    <= div_rd;
                    wb_data  <= div_data;
                    wb_exc   <= div_exc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// tb/tb_fpu_wb_arbiter.sv - directed self-checking bench for fpu_wb_arbiter
module tb_fpu_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_is_fma, issue_ready, issue_kill;
    logic [4:0]  issue_rd;
    logic        fma_res_valid, simple_res_valid;
    logic [63:0] fma_res_data, simple_res_data;
    logic [4:0]  fma_res_exc, simple_res_exc;
    logic        div_valid, div_ready;
    logic [4:0]  div_rd;
    logic [63:0] div_data;
    logic [4:0]  div_exc;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [4:0]  wb_exc;
    logic        err_protocol;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fpu_wb_arbiter dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_is_fma(issue_is_fma), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_kill(issue_kill),
        .fma_res_valid(fma_res_valid), .fma_res_data(fma_res_data), .fma_res_exc(fma_res_exc),
        .simple_res_valid(simple_res_valid), .simple_res_data(simple_res_data), .simple_res_exc(simple_res_exc),
        .div_valid(div_valid), .div_ready(div_ready), .div_rd(div_rd), .div_data(div_data), .div_exc(div_exc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc),
        .err_protocol(err_protocol)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_is_fma = 0; issue_rd = 0; issue_kill = 0;
        fma_res_valid = 0; fma_res_data = 0; fma_res_exc = 0;
        simple_res_valid = 0; simple_res_data = 0; simple_res_exc = 0;
        div_valid = 0; div_rd = 0; div_data = 0; div_exc = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
        checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
        checks++; if (wb_data !== 64'd0) begin failures++; $display("FAIL reset_wb_data got=%0h exp=0", wb_data); end
        checks++; if (wb_exc !== 5'd0) begin failures++; $display("FAIL reset_wb_exc got=%0h exp=0", wb_exc); end
        checks++; if (err_protocol !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_protocol); end
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL reset_issue_ready got=%0b exp=0", issue_ready); end
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL reset_div_ready got=%0b exp=0", div_ready); end
        reset = 0;
        #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL post_reset_issue_ready got=%0b exp=1", issue_ready); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL post_reset_div_ready got=%0b exp=1", div_ready); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        issue_valid = 1; issue_is_fma = 1; issue_rd = 3;             // t0
        #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL b2b_fma_ready got=%0b exp=1", issue_ready); end
        tick();
        issue_is_fma = 0; issue_rd = 7;                              // t1
        #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL b2b_simple_ready got=%0b exp=1", issue_ready); end
        tick();
        clear_inputs();                                              // t2
        simple_res_valid = 1; simple_res_data = 64'hAAAA_0000_0000_0007; simple_res_exc = 5'h01;
        #1;
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL b2b_div_ready_t2 got=%0b exp=0", div_ready); end
        tick();
        clear_inputs();                                              // t3
        fma_res_valid = 1; fma_res_data = 64'hBBBB_0000_0000_0003; fma_res_exc = 5'h02;
        checks++; if ({wb_valid, wb_rd} !== {1'b1, 5'd7}) begin failures++; $display("FAIL b2b_wb_t3 got=%0b/%0d exp=1/7", wb_valid, wb_rd); end
        checks++; if ({wb_data, wb_exc} !== {64'hAAAA_0000_0000_0007, 5'h01}) begin failures++; $display("FAIL b2b_data_t3 got=%0h/%0h exp=aaaa000000000007/1", wb_data, wb_exc); end
        tick();
        clear_inputs();                                              // t4
        checks++; if ({wb_valid, wb_rd} !== {1'b1, 5'd3}) begin failures++; $display("FAIL b2b_wb_t4 got=%0b/%0d exp=1/3", wb_valid, wb_rd); end
        checks++; if ({wb_data, wb_exc} !== {64'hBBBB_0000_0000_0003, 5'h02}) begin failures++; $display("FAIL b2b_data_t4 got=%0h/%0h exp=bbbb000000000003/2", wb_data, wb_exc); end
        tick();                                                      // t5
        checks++; if ({wb_valid, wb_rd} !== {1'b0, 5'd3}) begin failures++; $display("FAIL b2b_hold_t5 got=%0b/%0d exp=0/3", wb_valid, wb_rd); end
        checks++; if (err_protocol !== 1'b0) begin failures++; $display("FAIL b2b_err got=%0b exp=0", err_protocol); end
    endtask

    task automatic test_slot_conflict();
        clear_inputs();
        issue_valid = 1; issue_is_fma = 1; issue_rd = 1;             // t0
        tick();
        clear_inputs();                                              // t1
        tick();
        issue_valid = 1; issue_is_fma = 0; issue_rd = 2;             // t2
        #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL conflict_ready_t2 got=%0b exp=0", issue_ready); end
        tick();
        fma_res_valid = 1; fma_res_data = 64'h11; fma_res_exc = 5'h04; // t3: retry, FMA result due
        #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL conflict_ready_t3 got=%0b exp=1", issue_ready); end
        tick();
        clear_inputs();                                              // t4
        simple_res_valid = 1; simple_res_data = 64'h22; simple_res_exc = 5'h08;
        checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd1, 64'h11}) begin failures++; $display("FAIL conflict_fma_wb got=%0b/%0d/%0h exp=1/1/11", wb_valid, wb_rd, wb_data); end
        tick();
        clear_inputs();                                              // t5
        checks++; if ({wb_valid, wb_rd, wb_data, wb_exc} !== {1'b1, 5'd2, 64'h22, 5'h08}) begin failures++; $display("FAIL conflict_simple_wb got=%0b/%0d/%0h/%0h exp=1/2/22/8", wb_valid, wb_rd, wb_data, wb_exc); end
        tick();
        checks++; if ({wb_valid, err_protocol} !== 2'b00) begin failures++; $display("FAIL conflict_idle got=%0b/%0b exp=0/0", wb_valid, err_protocol); end
    endtask

    task automatic test_div_stall();
        clear_inputs();
        issue_valid = 1; issue_is_fma = 0; issue_rd = 4;             // t-1
        tick();
        issue_rd = 5;                                                // t0
        div_valid = 1; div_rd = 9; div_data = 64'hD1D1; div_exc = 5'h03;
        simple_res_valid = 1; simple_res_data = 64'hE4;
        #1;
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL div_ready_t0 got=%0b exp=0", div_ready); end
        tick();
        issue_valid = 0; simple_res_data = 64'hF5;                   // t1
        #1;
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL div_ready_t1 got=%0b exp=0", div_ready); end
        checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd4, 64'hE4}) begin failures++; $display("FAIL div_prev_wb_t1 got=%0b/%0d/%0h exp=1/4/e4", wb_valid, wb_rd, wb_data); end
        tick();
        simple_res_valid = 0;                                        // t2
        #1;
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL div_ready_t2 got=%0b exp=1", div_ready); end
        checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd5, 64'hF5}) begin failures++; $display("FAIL div_prev_wb_t2 got=%0b/%0d/%0h exp=1/5/f5", wb_valid, wb_rd, wb_data); end
        tick();
        clear_inputs();                                              // t3
        checks++; if ({wb_valid, wb_rd, wb_data, wb_exc} !== {1'b1, 5'd9, 64'hD1D1, 5'h03}) begin failures++; $display("FAIL div_wb_t3 got=%0b/%0d/%0h/%0h exp=1/9/d1d1/3", wb_valid, wb_rd, wb_data, wb_exc); end
        checks++; if (err_protocol !== 1'b0) begin failures++; $display("FAIL div_err got=%0b exp=0", err_protocol); end
        tick();
    endtask

    task automatic test_kill();
        clear_inputs();
        issue_valid = 1; issue_is_fma = 1; issue_rd = 6;             // t0
        tick();
        clear_inputs(); issue_kill = 1;                              // t1
        tick();
        clear_inputs();                                              // t2
        tick();
        #1;                                                          // t3
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL kill_div_ready_t3 got=%0b exp=1", div_ready); end
        tick();                                                      // t4
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL kill_wb_t4 got=%0b exp=0", wb_valid); end
        // simple op killed while in slot 0; its result still shows up and must vanish quietly
        issue_valid = 1; issue_is_fma = 0; issue_rd = 12;
        tick();
        clear_inputs(); issue_kill = 1;
        simple_res_valid = 1; simple_res_data = 64'h5A;
        #1;
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL kill_simple_div_ready got=%0b exp=1", div_ready); end
        tick();
        clear_inputs();
        checks++; if ({wb_valid, err_protocol} !== 2'b00) begin failures++; $display("FAIL kill_simple_drop got=%0b/%0b exp=0/0", wb_valid, err_protocol); end
        tick();
    endtask

    task automatic test_errors();
        clear_inputs();
        fma_res_valid = 1; fma_res_data = 64'hBAD;
        tick();
        clear_inputs();
        checks++; if ({err_protocol, wb_valid} !== 2'b10) begin failures++; $display("FAIL err_unreserved got=%0b/%0b exp=1/0", err_protocol, wb_valid); end
        tick();
        tick();
        checks++; if (err_protocol !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err_protocol); end
        do_reset();
        checks++; if (err_protocol !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0b exp=0", err_protocol); end
        issue_valid = 1; issue_is_fma = 0; issue_rd = 8;
        tick();
        clear_inputs();
        fma_res_valid = 1; simple_res_valid = 1; simple_res_data = 64'h88;
        tick();
        clear_inputs();
        checks++; if (err_protocol !== 1'b1) begin failures++; $display("FAIL err_both_valid got=%0b exp=1", err_protocol); end
        do_reset();
        issue_valid = 1; issue_is_fma = 0; issue_rd = 9;
        tick();
        clear_inputs();
        tick();
        checks++; if ({err_protocol, wb_valid} !== 2'b10) begin failures++; $display("FAIL err_missing_result got=%0b/%0b exp=1/0", err_protocol, wb_valid); end
        do_reset();
    endtask

    task automatic test_reset_midflight();
        clear_inputs();
        issue_valid = 1; issue_is_fma = 1; issue_rd = 10;            // t0
        tick();
        issue_rd = 11;                                               // t1
        #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL mid_second_ready got=%0b exp=1", issue_ready); end
        tick();
        clear_inputs(); reset = 1; fma_res_valid = 1; simple_res_valid = 1; // t2
        tick();
        clear_inputs(); reset = 0;                                   // t3
        #1;
        checks++; if ({wb_valid, wb_rd, wb_data, wb_exc, err_protocol} !== '0) begin failures++; $display("FAIL mid_outputs_t3 got=%0b/%0d/%0h/%0h/%0b exp=all0", wb_valid, wb_rd, wb_data, wb_exc, err_protocol); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL mid_div_ready_t3 got=%0b exp=1", div_ready); end
        tick();
        #1;                                                          // t4
        checks++; if ({wb_valid, div_ready} !== 2'b01) begin failures++; $display("FAIL mid_t4 got=%0b/%0b exp=0/1", wb_valid, div_ready); end
        tick();
        tick();                                                      // t6
        checks++; if ({wb_valid, err_protocol} !== 2'b00) begin failures++; $display("FAIL mid_t6 got=%0b/%0b exp=0/0", wb_valid, err_protocol); end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_back_to_back();
        test_slot_conflict();
        test_div_stall();
        test_kill();
        test_errors();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
